mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// Sequences data-memory loads/stores for the MEM stage. Latches the EX-stage access,
// drives a req/ack data-memory port with byte enables, stalls the pipeline until the
// access completes, and returns an aligned, sign/zero-extended load value with its rd.
// Sits between the EX->MEM pipeline register and the data memory.
// PARAMETERS
// ADDR_W          32  width of dmem_addr (byte address, low 2 bits always 0 on the bus)
// TIMEOUT_CYCLES  16  max BUSY cycles waiting for dmem_ack; 0 = no timeout
// PORTS
// clk             in   1   clock, all state on rising edge
// rst_n           in   1   asynchronous, active-low reset
// EX_mem_en       in   1   EX-stage instruction accesses memory
// EX_mem_wr       in   1   1 = store, 0 = load (valid with EX_mem_en)
// EX_funct3       in   3   RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
// EX_alu_val      in   32  effective byte address
// EX_rs2_val      in   32  store data
// EX_rd_sel       in   5   load destination register
// MEM_stall       out  1   hold IF..EX stages this cycle
// MEM_load_valid  out  1   1-cycle pulse: MEM_load_val/MEM_load_sel valid
// MEM_load_val    out  32  extended load result
// MEM_load_sel    out  5   rd of completed load
// MEM_bus_err     out  1   1-cycle pulse: access timed out
// MEM_misalign    out  1   1-cycle pulse: misaligned access trapped (0 without macro)
// dmem_req        out  1   request, held until ack or timeout
// dmem_we         out  1   write strobe, valid with dmem_req
// dmem_addr       out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
// dmem_wdata      out  32  store data, lane-replicated
// dmem_be         out  4   byte enables
// dmem_ack        in   1   access complete (rdata valid this cycle for loads)
// dmem_rdata      in   32  read word
// BEHAVIOUR
// - Reset: state IDLE; every output 0; latched addr/data/funct3/rd/timeout cnt 0.
// - States IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: EX_mem_en=1 -> latch EX_* fields, go BUSY; MEM_stall=EX_mem_en (combinational).
//   BUSY: dmem_req=1, bus fields registered from latches, stable until exit; MEM_stall=1.
//     dmem_ack=1 -> capture/extend rdata, go DONE. Timeout cnt reaches TIMEOUT_CYCLES
//     with no ack -> drop req, go DONE, MEM_bus_err=1 in DONE, load result 0.
//     ack and timeout in same cycle -> ack wins.
//   DONE: MEM_stall=0; MEM_load_valid=1 for loads without error; EX_mem_en ignored
//     (EX still holds the finished instruction); next cycle IDLE.
// - Min latency: stall 2 cycles (IDLE, BUSY w/ immediate ack); result in 3rd cycle.
// - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}};
//   SH be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}; SW be=1111, wdata=rs2.
// - Loads: select byte addr[1:0] / half addr[1]; B,H sign-extend, BU,HU zero-extend.
// - funct3 011/110/111 treated as word (010). dmem_be=0 on loads.
// - rst_n low mid-access: req drops asynchronously, access abandoned, no pulses.
// CONFIGURATION
// MEM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> no bus
//   request; IDLE -> DONE directly, MEM_misalign=1 in DONE, no load_valid, no write.
// Not defined: MEM_misalign tied 0; H ignores addr[0], W ignores addr[1:0].
// TESTING
// SW x, addr 0x100, rs2 0xDEADBEEF, ack after 2 cycles -> be=1111, wdata=DEADBEEF, stall 3 cycles.
// LB addr 0x103, rdata 0x80FF_1234 -> MEM_load_val 0xFFFF_FF80, load_valid 1 cycle, sel=rd.
// LHU addr 0x102, rdata 0x80FF_1234 -> 0x0000_80FF; SH addr 0x102 rs2 0xABCD -> be=1100, wdata 0xABCDABCD.
// No ack, TIMEOUT_CYCLES=16 -> req drops after 16 BUSY cycles, MEM_bus_err pulse, no load_valid.
// Back-to-back loads (EX_mem_en held) -> DONE ignores, 2nd access starts from IDLE next cycle.
// rst_n low in BUSY -> req/stall 0 immediately; with macro, LW addr 0x101 -> misalign pulse, no req.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: latches the EX access, runs a
// req/ack transfer with byte enables, stalls IF..EX, returns extended loads.
// Ports: clk, rst_n; EX_* access inputs; MEM_* stall/result/status outputs;
// dmem_* req/ack memory port. Optional macro MEM_MISALIGN_TRAP_EN traps
// misaligned half/word accesses without issuing a bus request.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EX_mem_en,
   input  logic              EX_mem_wr,
   input  logic [2:0]        EX_funct3,
   input  logic [31:0]       EX_alu_val,
   input  logic [31:0]       EX_rs2_val,
   input  logic [4:0]        EX_rd_sel,
   output logic              MEM_stall,
   output logic              MEM_load_valid,
   output logic [31:0]       MEM_load_val,
   output logic [4:0]        MEM_load_sel,
   output logic              MEM_bus_err,
   output logic              MEM_misalign,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata
);

   localparam int unsigned CNT_W =
      (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TMO_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   state_e             state_q, state_d;
   logic [1:0]         addr_lo_q;
   logic [2:0]         funct3_q;
   logic [4:0]         rd_q;
   logic               we_q;
   logic               err_q;
   logic               mis_q;
   logic [31:0]        val_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;

   logic               ex_byte, ex_half, ex_mis;
   logic [3:0]         st_be;
   logic [31:0]        st_wdata;
   logic               tmo_hit;
   logic               start;
   logic [31:0]        sh_b, sh_h, ld_val;
   logic               ld_sgn;

   // funct3[1:0]: 00 byte, 01 half, anything else is a word access
   always_comb begin
      ex_byte = (EX_funct3[1:0] == 2'b00);
      ex_half = (EX_funct3[1:0] == 2'b01);
`ifdef MEM_MISALIGN_TRAP_EN
      ex_mis  = ex_half ? EX_alu_val[0]
                        : (!ex_byte && (EX_alu_val[1:0] != 2'b00));
`else
      ex_mis  = 1'b0;
`endif
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = EX_rs2_val;
      unique case (1'b1)
         ex_byte: begin
            st_be    = 4'b0001 << EX_alu_val[1:0];
            st_wdata = {4{EX_rs2_val[7:0]}};
         end
         ex_half: begin
            st_be    = EX_alu_val[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{EX_rs2_val[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = EX_rs2_val;
         end
      endcase
   end

   // Lane extraction from the returned word using the latched offset
   always_comb begin
      ld_sgn = ~funct3_q[2];
      sh_b   = dmem_rdata >> {addr_lo_q, 3'b000};
      sh_h   = dmem_rdata >> {addr_lo_q[1], 4'b0000};
      unique case (1'b1)
         (funct3_q[1:0] == 2'b00):
            ld_val = {{24{ld_sgn & sh_b[7]}}, sh_b[7:0]};
         (funct3_q[1:0] == 2'b01):
            ld_val = {{16{ld_sgn & sh_h[15]}}, sh_h[15:0]};
         default:
            ld_val = dmem_rdata;
      endcase
   end

   always_comb begin
      tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);
      start   = (state_q == IDLE) && EX_mem_en;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (EX_mem_en) state_d = ex_mis ? DONE : BUSY;
         BUSY: if (dmem_ack || tmo_hit) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Access latches, bus fields and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_lo_q <= '0;
         funct3_q  <= '0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         mis_q     <= 1'b0;
         val_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
      end else if (start) begin
         addr_lo_q <= EX_alu_val[1:0];
         funct3_q  <= EX_funct3;
         rd_q      <= EX_rd_sel;
         we_q      <= EX_mem_wr;
         err_q     <= 1'b0;
         mis_q     <= ex_mis;
         val_q     <= '0;
         cnt_q     <= '0;
         addr_q    <= {EX_alu_val[ADDR_W-1:2], 2'b00};
         wdata_q   <= EX_mem_wr ? st_wdata : 32'h0;
         be_q      <= EX_mem_wr ? st_be : 4'h0;
      end else if (state_q == BUSY) begin
         // ack wins over a timeout landing in the same cycle
         if (dmem_ack) begin
            val_q <= we_q ? 32'h0 : ld_val;
         end else if (tmo_hit) begin
            err_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Outputs
   always_comb begin
      MEM_stall      = 1'b0;
      MEM_load_valid = 1'b0;
      MEM_bus_err    = 1'b0;
      MEM_misalign   = 1'b0;
      dmem_req       = 1'b0;
      dmem_we        = 1'b0;
      MEM_load_val   = val_q;
      MEM_load_sel   = rd_q;
      dmem_addr      = addr_q;
      dmem_wdata     = wdata_q;
      dmem_be        = be_q;
      unique case (state_q)
         IDLE: MEM_stall = EX_mem_en & rst_n;
         BUSY: begin
            MEM_stall = 1'b1;
            dmem_req  = 1'b1;
            dmem_we   = we_q;
         end
         DONE: begin
            MEM_load_valid = ~we_q & ~err_q & ~mis_q;
            MEM_bus_err    = err_q;
`ifdef MEM_MISALIGN_TRAP_EN
            MEM_misalign   = mis_q;
`endif
         end
         default: MEM_stall = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a spec-level access model.
// Checks bus fields every BUSY cycle and the result pulses in DONE.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        EX_mem_en = 1'b0, EX_mem_wr = 1'b0;
   logic [2:0]  EX_funct3 = '0;
   logic [31:0] EX_alu_val = '0, EX_rs2_val = '0;
   logic [4:0]  EX_rd_sel = '0;
   logic        MEM_stall, MEM_load_valid, MEM_bus_err, MEM_misalign;
   logic [31:0] MEM_load_val;
   logic [4:0]  MEM_load_sel;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;

   int n_vec = 0;
   int n_err = 0;

   mem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .EX_mem_en(EX_mem_en), .EX_mem_wr(EX_mem_wr),
      .EX_funct3(EX_funct3), .EX_alu_val(EX_alu_val),
      .EX_rs2_val(EX_rs2_val), .EX_rd_sel(EX_rd_sel),
      .MEM_stall(MEM_stall), .MEM_load_valid(MEM_load_valid),
      .MEM_load_val(MEM_load_val), .MEM_load_sel(MEM_load_sel),
      .MEM_bus_err(MEM_bus_err), .MEM_misalign(MEM_misalign),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---- reference model: access size in bytes and lane arithmetic ----
   function automatic int acc_size(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
      int s, o;
      s = acc_size(f3);
      o = int'(a % 4);
      return o - (o % s);
   endfunction

   function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
      return (a % acc_size(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      int s;
      s = acc_size(f3);
      return 4'(((1 << s) - 1) << lane_off(f3, a));
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
      case (acc_size(f3))
         1:       return {24'h0, d[7:0]} * 32'h0101_0101;
         2:       return {16'h0, d[15:0]} * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
      longint v, lim;
      int s;
      s   = acc_size(f3);
      v   = longint'(w >> (8 * lane_off(f3, a)));
      if (s == 4) return w;
      lim = longint'(1) << (8 * s);
      v   = v % lim;
      if (f3[2] == 1'b0 && v >= lim / 2) v = v - lim;
      return 32'(v);
   endfunction

   // One complete access; dly = BUSY cycles before ack, >= 16 means no ack
   task automatic access(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input int dly,
                         input logic [31:0] rdata);
      bit m, err;
      m   = is_mis(f3, a);
      err = 1'b0;
      EX_mem_en = 1'b1; EX_mem_wr = wr; EX_funct3 = f3;
      EX_alu_val = a; EX_rs2_val = d; EX_rd_sel = rd;
      dmem_ack = 1'b0;
      @(negedge clk);
      chk("idle_stall", 32'(MEM_stall), 32'd1);
      chk("idle_req", 32'(dmem_req), 32'd0);
      if (!m) begin
         err = 1'b1;
         for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            dmem_ack   = (k == dly + 1);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            @(negedge clk);
            chk("busy_req", 32'(dmem_req), 32'd1);
            chk("busy_stall", 32'(MEM_stall), 32'd1);
            chk("busy_we", 32'(dmem_we), 32'(wr));
            chk("busy_addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("busy_be", 32'(dmem_be), wr ? 32'(exp_be(f3, a)) : 32'd0);
            if (wr) chk("busy_wdata", dmem_wdata, exp_wd(f3, d));
            if (dmem_ack) begin
               err = 1'b0;
               break;
            end
         end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      @(negedge clk);
      chk("done_stall", 32'(MEM_stall), 32'd0);
      chk("done_req", 32'(dmem_req), 32'd0);
      chk("done_lvalid", 32'(MEM_load_valid), 32'(!wr && !m && !err));
      chk("done_buserr", 32'(MEM_bus_err), 32'(!m && err));
      chk("done_misal", 32'(MEM_misalign), 32'(m));
      if (!wr && !m) begin
         chk("done_lval", MEM_load_val, err ? 32'h0 : exp_ld(f3, a, rdata));
         chk("done_lsel", 32'(MEM_load_sel), 32'(rd));
      end
      @(posedge clk); #1;
   endtask

   task automatic gap();
      EX_mem_en = 1'b0;
      @(negedge clk);
      chk("gap_stall", 32'(MEM_stall), 32'd0);
      chk("gap_req", 32'(dmem_req), 32'd0);
      chk("gap_lvalid", 32'(MEM_load_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic reset_mid();
      EX_mem_en = 1'b1; EX_mem_wr = 1'b1; EX_funct3 = 3'b010;
      EX_alu_val = 32'h0000_0300; EX_rs2_val = 32'h1234_5678;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_pre_req", 32'(dmem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(MEM_stall), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      EX_mem_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_lvalid", 32'(MEM_load_valid), 32'd0);
      chk("rst_buserr", 32'(MEM_bus_err), 32'd0);
      chk("rst_req2", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [2:0] f3;
      logic       wr;
      int         dly;
      logic [2:0] st_codes [3];
      st_codes = '{3'b000, 3'b001, 3'b010};
      #12;
      chk("rst_stall0", 32'(MEM_stall), 32'd0);
      chk("rst_lvalid0", 32'(MEM_load_valid), 32'd0);
      chk("rst_lval0", MEM_load_val, 32'd0);
      chk("rst_lsel0", 32'(MEM_load_sel), 32'd0);
      chk("rst_err0", 32'(MEM_bus_err), 32'd0);
      chk("rst_mis0", 32'(MEM_misalign), 32'd0);
      chk("rst_req0", 32'(dmem_req), 32'd0);
      chk("rst_we0", 32'(dmem_we), 32'd0);
      chk("rst_addr0", dmem_addr, 32'd0);
      chk("rst_wd0", dmem_wdata, 32'd0);
      chk("rst_be0", 32'(dmem_be), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 1, 32'h0);
      gap();
      access(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_1234);
      access(1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 0, 32'h80FF_1234);
      access(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0, 0, 32'h0);
      access(1'b0, 3'b010, 32'h200, 32'h0, 5'd3, 16, 32'h5555_AAAA);
      access(1'b0, 3'b000, 32'h204, 32'h0, 5'd4, 15, 32'h0000_7F00);
      access(1'b0, 3'b010, 32'h101, 32'h0, 5'd5, 0, 32'hCAFE_F00D);
      gap();
      reset_mid();

      for (int i = 0; i < 300; i++) begin
         wr = ($urandom % 3) == 0;
         f3 = wr ? st_codes[$urandom % 3] : 3'($urandom);
         dly = (($urandom % 8) == 0) ? 16 : int'($urandom % 4);
         access(wr, f3, $urandom, $urandom, 5'($urandom), dly, $urandom);
         if (($urandom % 4) == 0) gap();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
